uart_line_arbiter: RTL
======================

// Module: uart_line_arbiter
// PURPOSE
//  Shares one UART transmitter between N byte-stream requesters, at line granularity.
//  Each grant lasts until the granted requester sends LF (8'h0A), so lines from different sources never interleave.
//  Sits between the sequencer's debug and status producers and the UART TX core.
//  The bench UART model prints whole lines on CR/LF, so this arbitration keeps log output readable.
// PARAMETERS
//  N_REQ        4      number of requesters (2..8)
//  TIMEOUT_CYC  1024   idle cycles before a held grant is revoked (used only with UART_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1        system clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  req_valid  in   N_REQ    per-requester byte valid
//  req_data   in   8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
//  req_ready  out  N_REQ    per-requester accept; at most one bit set
//  tx_valid   out  1        byte valid to the UART TX core
//  tx_data    out  8        byte to the UART TX core
//  tx_ready   in   1        UART TX core can accept a byte
//  grant      out  N_REQ    one-hot owner of the UART; all zero when idle
//  busy       out  1        high while in LOCKED
// BEHAVIOUR
//  - Reset values: grant=0, busy=0, tx_valid=0, req_ready=0, tx_data=8'h00; state=IDLE; rr_ptr=N_REQ-1 (requester 0 wins first).
//  - FSM has two states: IDLE and LOCKED.
//  - IDLE:
//    - If any req_valid is high, pick the first requester at or after rr_ptr+1, modulo N_REQ.
//    - Register grant to that requester and go to LOCKED.
//    - Latency: one cycle from req_valid to grant. No transfer happens in IDLE.
//  - LOCKED, owner g; the datapath is combinational pass-through:
//    - tx_valid = req_valid[g]
//    - tx_data = req_data[g]
//    - req_ready[g] = tx_ready
//    - every other req_ready bit = 0
//  - A transfer occurs when tx_valid && tx_ready are both high.
//  - If the transferred byte is LF: next state IDLE, grant cleared, rr_ptr <= g.
//    The LF byte itself is delivered.
//  - CR (8'h0D) and all other bytes keep the grant. A CR LF pair therefore stays within one grant.
//  - A requester that raises req_valid must hold req_data stable until it sees req_ready. The arbiter never revokes a grant while tx_valid is high.
//  - Requests from non-owners wait. They are unaffected and are never dropped.
//  - Simultaneous events:
//    - LF transfer in cycle t: IDLE in cycle t+1, new grant in t+2. No two owners in the same cycle.
//    - An owner that releases on LF and requests again still goes behind the other pending requesters.
//  - Reset mid-line: grant is dropped at once and the partial line is abandoned. The requester is responsible for its own recovery.
//  - tx_ready low for any number of cycles: grant is held, no timeout advance while tx_valid is high.
// CONFIGURATION
//  - UART_ARB_TIMEOUT_EN defined:
//    - 16-bit idle counter, cleared on grant and on every transfer.
//    - Increments in LOCKED while req_valid[g]=0.
//    - At TIMEOUT_CYC it forces IDLE with rr_ptr <= g. A silent owner cannot starve the others.
//  - UART_ARB_TIMEOUT_EN undefined: no counter; the grant is held indefinitely until LF.
// STRUCTURE
//  - Package uart_arb_pkg holds:
//    - ASCII_LF = 8'h0A and ASCII_CR = 8'h0D
//    - state encoding: ST_IDLE = 1'b0, ST_LOCKED = 1'b1
//    - TIMEOUT counter width
//  - Sub-module uart_rr_pick: combinational round-robin picker.
//    - Inputs: req[N_REQ], ptr.
//    - Outputs: one-hot pick, index, any.
//    - Reused by the future SPI-log arbiter.
// TESTING
//  1. Single requester:
//     - Stimulus: req 0 sends "AB\r\n", tx_ready tied 1.
//     - Required: grant=0001 one cycle after req_valid. tx_data sequence 41,42,0D,0A. Back to IDLE after 0A.
//  2. Contention:
//     - Stimulus: req 0 and req 2 both valid in the same cycle, each sending a 3-byte line ending in 0A.
//     - Required: req 0's line completes, then grant=0100 for req 2's line. The bytes of the two lines never interleave.
//  3. Fairness:
//     - Stimulus: all 4 requesters hold valid continuously, each sending 1-byte "\n" lines.
//     - Required: grant order 0,1,2,3,0. Each grant lasts exactly one transfer.
//  4. Backpressure:
//     - Stimulus: tx_ready low for 50 cycles mid-line.
//     - Required: tx_data stable and grant held. No byte lost or duplicated once tx_ready returns.
//  5. Reset mid-line:
//     - Stimulus: assert rst asynchronously after 2 bytes of a line.
//     - Required: all outputs at reset values immediately. After release, requester 0 has priority.
//  6. UART_ARB_TIMEOUT_EN, TIMEOUT_CYC=16:
//     - Stimulus: owner 1 sends "X", then goes silent; req 3 is waiting.
//     - Required: after 16 idle cycles, grant moves to 3.
//     - Without the macro: grant stays at 1 for 200 cycles.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// ----------------------------------------------------------------------------
// uart_arb_pkg
//   Shared constants and types for the line-granular UART arbiter.
//   ASCII_LF ends a line and releases the grant. ASCII_CR is an ordinary byte
//   for arbitration purposes. TO_CNT_W is the width of the idle-timeout counter
//   that exists only when UART_ARB_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
package uart_arb_pkg;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  localparam int unsigned TO_CNT_W = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// ----------------------------------------------------------------------------
// uart_rr_pick
//   Combinational round-robin picker. It selects the first set bit of req at
//   or after position ptr+1, wrapping modulo N_REQ. ptr is the index of the
//   previous winner, so that winner gets the lowest priority.
// Ports
//   req    in   N_REQ   request vector
//   ptr    in   IDX_W   index of the previous winner
//   pick   out  N_REQ   one-hot winner (all zero when no request)
//   index  out  IDX_W   binary index of the winner (0 when no request)
//   any    out  1       at least one request is present
// ----------------------------------------------------------------------------
module uart_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Scan in priority order: ptr+1, ptr+2, ..., ptr (wrapped).
  always_comb begin
    pick  = '0;
    index = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % N_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        index       = cand;
        pick[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_line_arbiter.sv
// ----------------------------------------------------------------------------
// uart_line_arbiter
//   Shares one UART transmitter between N_REQ byte-stream requesters. A grant
//   lasts until the owner's LF byte is transferred, so lines never interleave.
//   Grant selection is round-robin; the owner that just released goes behind
//   every other pending requester.
//
//   Optional feature (macro UART_ARB_TIMEOUT_EN): a 16-bit idle counter revokes
//   the grant after TIMEOUT_CYC consecutive-or-not cycles in which the owner
//   has no valid byte (counter cleared on grant and on every transfer).
//   Without the macro the grant is held until LF.
//
// Ports
//   clk        in   1         system clock, rising edge
//   rst        in   1         asynchronous active-high reset
//   req_valid  in   N_REQ     per-requester byte valid
//   req_data   in   8*N_REQ   per-requester byte, requester i at [8i+7:8i]
//   req_ready  out  N_REQ     per-requester accept, at most one bit set
//   tx_valid   out  1         byte valid towards the UART TX core
//   tx_data    out  8         byte towards the UART TX core
//   tx_ready   in   1         UART TX core accepts a byte
//   grant      out  N_REQ     one-hot owner, zero when idle (registered)
//   busy       out  1         high while LOCKED (registered)
// ----------------------------------------------------------------------------
module uart_line_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               busy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("uart_line_arbiter: N_REQ must be in 2..8");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("uart_line_arbiter: TIMEOUT_CYC must fit the 16-bit idle counter");
  end

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             xfer;
  logic             timeout_hit;
  logic             release_line;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .pick  (pick_onehot),
    .index (pick_idx),
    .any   (pick_any)
  );

  // Combinational pass-through from the owner while LOCKED; quiet otherwise.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    req_ready = '0;
    if (state_q == ST_LOCKED) begin
      tx_valid           = req_valid[owner_q];
      tx_data            = req_data[{owner_q, 3'b000} +: 8];
      req_ready[owner_q] = tx_ready;
    end
  end

  assign xfer = tx_valid & tx_ready;

`ifdef UART_ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  // Revocation only happens while the owner presents nothing, so a byte on
  // the bus is never pulled away.
  assign timeout_hit = (state_q == ST_LOCKED) && !req_valid[owner_q] &&
                       (idle_cnt_q == TO_CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (state_q == ST_IDLE || xfer || timeout_hit) begin
      idle_cnt_d = '0;
    end else if (!req_valid[owner_q]) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign release_line = (xfer && (tx_data == ASCII_LF)) || timeout_hit;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_LOCKED;
          grant_d = pick_onehot;
          owner_d = pick_idx;
        end
      end
      ST_LOCKED: begin
        if (release_line) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= IDX_W'(N_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
`ifdef UART_ARB_TIMEOUT_EN
      idle_cnt_q <= idle_cnt_d;
`endif
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == ST_LOCKED);

endmodule
